// File: rtl/cs42448_tdm_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cs42448_tdm_rx : oversampled 8x32 TDM capture from the CS42448 ADC port, |
// | 24-bit samples tagged with slot index, buffered in a FWFT FIFO.           |
// | Option macro: CS42448_TDM_RX_CHMASK_EN (adds per-slot ch_mask input).     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module cs42448_tdm_rx #(
   parameter int SLOTS      = 8,
   parameter int SLOT_BITS  = 32,
   parameter int DATA_BITS  = 24,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                       sys_clk,
   input  logic                       sys_nrst,
   input  logic                       adc_sclk,
   input  logic                       adc_lrck,
   input  logic                       adc_sdin,
`ifdef CS42448_TDM_RX_CHMASK_EN
   input  logic [SLOTS-1:0]           ch_mask,
`endif
   output logic [DATA_BITS-1:0]       out_data,
   output logic [$clog2(SLOTS)-1:0]   out_ch,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       frame_err,
   output logic                       overflow
);

   localparam int c_ch_w   = $clog2(SLOTS);
   localparam int c_bit_w  = $clog2(SLOT_BITS);
   localparam int c_addr_w = $clog2(FIFO_DEPTH);
   localparam int c_ptr_w  = c_addr_w + 1;
   localparam int c_word_w = DATA_BITS + c_ch_w;
   localparam logic [c_bit_w-1:0] c_bit_max  = c_bit_w'(SLOT_BITS - 1);
   localparam logic [c_ch_w-1:0]  c_slot_max = c_ch_w'(SLOTS - 1);

   typedef enum logic [0:0] {
      S_HUNT  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   // Synchronisers plus the registered edge strobe and the data sampled with it
   logic r_sclk_meta, r_sclk_sync, r_sclk_prev;
   logic r_lrck_meta, r_lrck_sync;
   logic r_sdin_meta, r_sdin_sync;
   logic r_edge, r_edge_lrck, r_edge_sdin;

   always_ff @(posedge sys_clk or negedge sys_nrst) begin
      if (!sys_nrst) begin
         r_sclk_meta <= 1'b0;
         r_sclk_sync <= 1'b0;
         r_sclk_prev <= 1'b0;
         r_lrck_meta <= 1'b0;
         r_lrck_sync <= 1'b0;
         r_sdin_meta <= 1'b0;
         r_sdin_sync <= 1'b0;
         r_edge      <= 1'b0;
         r_edge_lrck <= 1'b0;
         r_edge_sdin <= 1'b0;
      end else begin
         r_sclk_meta <= adc_sclk;
         r_sclk_sync <= r_sclk_meta;
         r_sclk_prev <= r_sclk_sync;
         r_lrck_meta <= adc_lrck;
         r_lrck_sync <= r_lrck_meta;
         r_sdin_meta <= adc_sdin;
         r_sdin_sync <= r_sdin_meta;
         r_edge      <= r_sclk_sync & ~r_sclk_prev;
         r_edge_lrck <= r_lrck_sync;
         r_edge_sdin <= r_sdin_sync;
      end
   end

   state_t                 r_state;
   logic [c_bit_w-1:0]     r_bit_cnt;
   logic [c_ch_w-1:0]      r_slot_cnt;
   logic [SLOT_BITS-1:0]   r_shift;
   logic                   r_lrck_prev;
   logic                   r_push;
   logic [c_word_w-1:0]    r_push_data;

   logic                   w_sync;
   logic                   w_last_slot;
   logic                   w_frame_end;
   logic                   w_slot_en;
   logic [SLOT_BITS-1:0]   w_shift_next;

   assign w_sync       = r_edge_lrck & ~r_lrck_prev;
   assign w_last_slot  = (r_slot_cnt == c_slot_max);
   assign w_frame_end  = (r_bit_cnt == '0) && w_last_slot;
   assign w_shift_next = {r_shift[SLOT_BITS-2:0], r_edge_sdin};
`ifdef CS42448_TDM_RX_CHMASK_EN
   assign w_slot_en    = ch_mask[r_slot_cnt];
`else
   assign w_slot_en    = 1'b1;
`endif

   always_ff @(posedge sys_clk or negedge sys_nrst) begin
      if (!sys_nrst) begin
         r_state     <= S_HUNT;
         r_bit_cnt   <= '0;
         r_slot_cnt  <= '0;
         r_shift     <= '0;
         r_lrck_prev <= 1'b0;
         r_push      <= 1'b0;
         r_push_data <= '0;
         frame_err   <= 1'b0;
      end else begin
         r_push    <= 1'b0;
         frame_err <= 1'b0;
         if (r_edge) begin
            r_lrck_prev <= r_edge_lrck;
            case (r_state)
               S_HUNT: begin
                  if (w_sync) begin
                     r_state    <= S_SHIFT;
                     r_bit_cnt  <= c_bit_max;
                     r_slot_cnt <= '0;
                  end
               end
               S_SHIFT: begin
                  r_shift <= w_shift_next;
                  // A sync on the last bit of slot 7 is the back-to-back frame start
                  if (w_sync && !w_frame_end) begin
                     frame_err  <= 1'b1;
                     r_bit_cnt  <= c_bit_max;
                     r_slot_cnt <= '0;
                  end else if (r_bit_cnt == '0) begin
                     r_push      <= w_slot_en;
                     r_push_data <= {w_shift_next[SLOT_BITS-1 -: DATA_BITS], r_slot_cnt};
                     r_bit_cnt   <= c_bit_max;
                     if (w_last_slot) begin
                        r_slot_cnt <= '0;
                        r_state    <= w_sync ? S_SHIFT : S_HUNT;
                     end else begin
                        r_slot_cnt <= r_slot_cnt + 1'b1;
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt - 1'b1;
                  end
               end
               default: r_state <= S_HUNT;
            endcase
         end
      end
   end

   logic [c_word_w-1:0]  r_mem [FIFO_DEPTH];
   logic [c_ptr_w-1:0]   r_wr_ptr, r_rd_ptr;
   logic [c_ptr_w-1:0]   w_wr_ptr_nxt, w_rd_ptr_nxt;
   logic                 w_full, w_pop, w_wr_en;
   logic [c_word_w-1:0]  w_head;

   assign w_full       = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                         (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
   assign w_pop        = out_valid & out_ready;
   assign w_wr_en      = r_push & (~w_full | w_pop);
   assign w_wr_ptr_nxt = r_wr_ptr + c_ptr_w'(w_wr_en);
   assign w_rd_ptr_nxt = r_rd_ptr + c_ptr_w'(w_pop);

   // Output register is preloaded with the next head; bypass covers a write into that slot
   always_comb begin
      w_head = r_mem[w_rd_ptr_nxt[c_addr_w-1:0]];
      if (w_wr_en && (r_wr_ptr[c_addr_w-1:0] == w_rd_ptr_nxt[c_addr_w-1:0]))
         w_head = r_push_data;
   end

   always_ff @(posedge sys_clk) begin
      if (w_wr_en)
         r_mem[r_wr_ptr[c_addr_w-1:0]] <= r_push_data;
   end

   always_ff @(posedge sys_clk or negedge sys_nrst) begin
      if (!sys_nrst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         overflow  <= 1'b0;
      end else begin
         r_wr_ptr  <= w_wr_ptr_nxt;
         r_rd_ptr  <= w_rd_ptr_nxt;
         out_valid <= (w_wr_ptr_nxt != w_rd_ptr_nxt);
         overflow  <= r_push & w_full & ~w_pop;
         if (w_wr_ptr_nxt != w_rd_ptr_nxt) begin
            out_data <= w_head[c_word_w-1 -: DATA_BITS];
            out_ch   <= w_head[c_ch_w-1:0];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cs42448_tdm_rx.sv
`default_nettype none
`timescale 1ns/1ps
// Scoreboard bench for cs42448_tdm_rx: bit-level TDM stimulus, expected words queued, monitor pops.
module tb_cs42448_tdm_rx;

   logic        sys_clk   = 1'b0;
   logic        sys_nrst  = 1'b0;
   logic        adc_sclk  = 1'b0;
   logic        adc_lrck  = 1'b0;
   logic        adc_sdin  = 1'b0;
   logic        out_ready = 1'b0;
   logic [23:0] out_data;
   logic [2:0]  out_ch;
   logic        out_valid;
   logic        frame_err;
   logic        overflow;
`ifdef CS42448_TDM_RX_CHMASK_EN
   logic [7:0]  ch_mask = 8'hFF;
`endif

   int total = 0;
   int bad   = 0;
   int err_cnt = 0;
   int ovf_cnt = 0;
   logic [26:0] exp_q[$];

   cs42448_tdm_rx dut (
      .sys_clk   (sys_clk),
      .sys_nrst  (sys_nrst),
      .adc_sclk  (adc_sclk),
      .adc_lrck  (adc_lrck),
      .adc_sdin  (adc_sdin),
`ifdef CS42448_TDM_RX_CHMASK_EN
      .ch_mask   (ch_mask),
`endif
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .frame_err (frame_err),
      .overflow  (overflow)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #3ms;
      $display("FAIL watchdog: got timeout want test completion");
      $fatal(1, "watchdog");
   end

   // Monitor: counts pulse cycles and checks every accepted word against the queue
   always @(negedge sys_clk) begin
      logic [26:0] exp_w;
      if (sys_nrst) begin
         if (frame_err) err_cnt++;
         if (overflow)  ovf_cnt++;
         if (out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_word: got ch=%0d data=%h want no word", out_ch, out_data);
            end else begin
               exp_w = exp_q.pop_front();
               if ({out_ch, out_data} !== exp_w) begin
                  bad++;
                  $display("FAIL word: got ch=%0d data=%h want ch=%0d data=%h",
                           out_ch, out_data, exp_w[26:24], exp_w[23:0]);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] slot_word(input logic [23:0] base, input int s);
      return {base + 24'(s), 8'h00};
   endfunction

   // One SCLK period, edges placed 2 ns after a sys_clk rise for deterministic latency
   task automatic tx_bit(input logic l, input logic d, input bit pop = 1'b0);
      adc_lrck = l;
      adc_sdin = d;
      repeat (4) @(posedge sys_clk);
      #2 adc_sclk = 1'b1;
      repeat (4) @(posedge sys_clk);
      #1;
      if (pop) out_ready = 1'b1;
      #1 adc_sclk = 1'b0;
   endtask

   task automatic tx_frame(input logic [23:0] base, input bit lead, input bit trail);
      logic [31:0] w;
      if (lead) tx_bit(1'b1, 1'b0);
      for (int s = 0; s < 8; s++) begin
         w = slot_word(base, s);
         for (int b = 31; b >= 0; b--)
            tx_bit((trail && s == 7 && b == 0) ? 1'b1 : 1'b0, w[b]);
      end
   endtask

   task automatic expect_slots(input logic [23:0] base, input int first, input int last);
      for (int s = first; s <= last; s++)
         exp_q.push_back({3'(s), base + 24'(s)});
   endtask

   task automatic idle_bits(input int n);
      for (int i = 0; i < n; i++) tx_bit(1'b0, 1'b0);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 4000) begin
         @(posedge sys_clk);
         n++;
      end
      repeat (20) @(posedge sys_clk);
      check(name, exp_q.size(), 0);
   endtask

   task automatic check_zero_outputs(input string tag);
      @(negedge sys_clk);
      check({tag, "_data"},  out_data,  0);
      check({tag, "_ch"},    out_ch,    0);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_ferr"},  frame_err, 0);
      check({tag, "_ovf"},   overflow,  0);
   endtask

   initial begin
      logic [31:0] w;

      // Reset state
      repeat (5) @(posedge sys_clk);
      check_zero_outputs("reset");
      #2 sys_nrst = 1'b1;
      repeat (5) @(posedge sys_clk);

      // Clean frame, consumer always ready
      out_ready = 1'b1;
      err_cnt = 0; ovf_cnt = 0;
      expect_slots(24'hA5A500, 0, 7);
      tx_frame(24'hA5A500, 1'b1, 1'b0);
      idle_bits(2);
      wait_drain("clean_drain");
      check("clean_ferr", err_cnt, 0);
      check("clean_ovf",  ovf_cnt, 0);

      // Two back-to-back frames with consumer stalled: second frame overflows
      out_ready = 1'b0;
      err_cnt = 0; ovf_cnt = 0;
      expect_slots(24'h111100, 0, 7);
      tx_frame(24'h111100, 1'b1, 1'b1);
      tx_frame(24'h222200, 1'b0, 1'b0);
      idle_bits(2);
      check("stall_ovf",    ovf_cnt, 8);
      check("stall_ferr",   err_cnt, 0);
      check("stall_queued", exp_q.size(), 8);
      check("stall_valid",  out_valid, 1);
      out_ready = 1'b1;
      wait_drain("stall_drain");
      check("stall_empty",  out_valid, 0);

      // Misaligned sync after slot 3 bit 15, then a full realigned frame
      err_cnt = 0; ovf_cnt = 0;
      expect_slots(24'h333300, 0, 2);
      expect_slots(24'h444400, 0, 7);
      tx_bit(1'b1, 1'b0);
      for (int s = 0; s < 3; s++) begin
         w = slot_word(24'h333300, s);
         for (int b = 31; b >= 0; b--) tx_bit(1'b0, w[b]);
      end
      w = slot_word(24'h333300, 3);
      for (int b = 31; b >= 15; b--) tx_bit(1'b0, w[b]);
      tx_frame(24'h444400, 1'b1, 1'b0);
      idle_bits(2);
      wait_drain("misalign_drain");
      check("misalign_ferr", err_cnt, 1);
      check("misalign_ovf",  ovf_cnt, 0);

      // Full FIFO, pop lands on the push cycle of the next sample
      out_ready = 1'b0;
      err_cnt = 0; ovf_cnt = 0;
      expect_slots(24'h555500, 0, 7);
      expect_slots(24'h666600, 0, 7);
      tx_frame(24'h555500, 1'b1, 1'b0);
      idle_bits(2);
      check("full_valid", out_valid, 1);
      tx_bit(1'b1, 1'b0);
      for (int s = 0; s < 8; s++) begin
         w = slot_word(24'h666600, s);
         for (int b = 31; b >= 0; b--) tx_bit(1'b0, w[b], (s == 0 && b == 0));
      end
      idle_bits(2);
      wait_drain("fullpop_drain");
      check("fullpop_ovf",  ovf_cnt, 0);
      check("fullpop_ferr", err_cnt, 0);

      // Reset in the middle of slot 5; capture resumes only at the next sync
      out_ready = 1'b1;
      err_cnt = 0; ovf_cnt = 0;
      expect_slots(24'h777700, 0, 4);
      tx_bit(1'b1, 1'b0);
      for (int s = 0; s < 5; s++) begin
         w = slot_word(24'h777700, s);
         for (int b = 31; b >= 0; b--) tx_bit(1'b0, w[b]);
      end
      w = slot_word(24'h777700, 5);
      for (int b = 31; b >= 20; b--) tx_bit(1'b0, w[b]);
      check("prereset_queue", exp_q.size(), 0);
      sys_nrst = 1'b0;
      repeat (3) @(posedge sys_clk);
      check_zero_outputs("midreset");
      #2 sys_nrst = 1'b1;
      for (int b = 19; b >= 0; b--) tx_bit(1'b0, w[b]);
      for (int s = 6; s < 8; s++) begin
         w = slot_word(24'h777700, s);
         for (int b = 31; b >= 0; b--) tx_bit(1'b0, w[b]);
      end
      idle_bits(2);
      check("postreset_quiet", out_valid, 0);
      expect_slots(24'h888800, 0, 7);
      tx_frame(24'h888800, 1'b1, 1'b0);
      idle_bits(2);
      wait_drain("postreset_drain");
      check("postreset_ferr", err_cnt, 0);

`ifdef CS42448_TDM_RX_CHMASK_EN
      // Only slots 0 and 2 enabled
      ch_mask = 8'h05;
      err_cnt = 0; ovf_cnt = 0;
      exp_q.push_back({3'd0, 24'h5A5A00});
      exp_q.push_back({3'd2, 24'h5A5A02});
      tx_frame(24'h5A5A00, 1'b1, 1'b0);
      idle_bits(2);
      wait_drain("mask_drain");
      check("mask_ovf", ovf_cnt, 0);
      ch_mask = 8'hFF;
`endif

      repeat (10) @(posedge sys_clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
